// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_ovf;
`endif

    logic w_fa_sum;
    logic w_fa_carry;

    // The single full-adder cell
    assign w_fa_sum   = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_fa_carry = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts start exactly like IDLE so adds can run back to back
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_carry;
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    if (r_cnt == LAST_BIT) begin
                        // r_carry here is the carry into the MSB
                        r_cout  <= w_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= r_carry ^ w_fa_carry;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, hand-written corner sequences and
// random adds against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    // Reference: plain integer addition of the operands
    function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y, logic c);
        longint t;
        t = longint'(x) + longint'(y) + longint'(c);
        return t[W:0];
    endfunction

    // Reference: signed result falls outside the W-bit two's-complement range
    function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic c);
        longint sx, sy, r;
        sx = longint'(x) - (x[W-1] ? (longint'(1) <<< W) : 0);
        sy = longint'(y) - (y[W-1] ? (longint'(1) <<< W) : 0);
        r  = sx + sy + longint'(c);
        return (r > ((longint'(1) <<< (W-1)) - 1)) || (r < -(longint'(1) <<< (W-1)));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cyc;
        int bcnt;
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_cycles));
        check({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_cycles));
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic ic, input logic [W-1:0] es, input logic ec);
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({name, "_ovf"}, 64'(ovf), 64'(ref_ovf(ia, ib, ic)));
`endif
        $display("add %s: %02h + %02h + %0d -> sum=%02h cout=%0d", name, ia, ib, ic, sum, cout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        logic         rc;
        int           pulses;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done($sformatf("vec%0d", i), W);
            check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                         vecs[i].exp_sum, vecs[i].exp_cout);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
        end

        // Back-to-back: second start issued in the DONE cycle
        issue(8'h5A, 8'h3C, 1'b1);
        wait_done("b2b_first", W);
        check_result("b2b_first", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0);
        issue(8'h80, 8'h80, 1'b0);
        wait_done("b2b_second", W);
        check_result("b2b_second", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        @(negedge clk);

        // start re-pulsed during RUN must be ignored
        issue(8'h0F, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse", W - 3);
        check_result("repulse", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("repulse_extra_done", 64'(pulses), 64'd0);

        // Reset mid-RUN aborts the add
        issue(8'hFF, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_busy", 64'(busy), 64'd0);
        check("midrun_done", 64'(done), 64'd0);
        check("midrun_sum", 64'(sum), 64'd0);
        check("midrun_cout", 64'(cout), 64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrun_no_done", 64'(pulses), 64'd0);
        issue(8'h01, 8'h02, 1'b0);
        wait_done("after_reset", W);
        check_result("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
        @(negedge clk);

        // Random adds against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            r  = ref_add(ra, rb, rc);
            issue(ra, rb, rc);
            wait_done($sformatf("rand%0d", i), W);
            check_result($sformatf("rand%0d", i), ra, rb, rc, r[W-1:0], r[W]);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial binary adder built around a single full-adder cell plus sequential control.
- Feeds the full adder one operand bit pair per cycle, LSB first, and registers the carry between cycles.
- Consumes the full adder's sum/carry outputs and assembles a WIDTH-bit result.
- Sits beside the ripple-carry adders as the area-minimal alternative: one cell, WIDTH cycles per add.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
- start  input  1  request to begin an addition; sampled only when not busy.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  output  WIDTH  result; held stable until the next accepted start.
- cout  output  1  final carry-out; held like sum.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, bit counter=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge loads the operand shift registers with a and b, loads the carry register with cin, clears the counter, and moves to RUN. busy rises after that edge.
- RUN: each cycle the full-adder cell takes a_sr[0], b_sr[0] and the carry register.
  - Its sum bit is shifted into the result register from the MSB end.
  - Its carry output is written to the carry register.
  - Both operand shift registers shift right and the counter increments.
- After WIDTH RUN edges (counter has processed bit WIDTH-1), move to DONE.
- DONE: lasts exactly one cycle. done=1, busy=0, sum=a+b+cin mod 2^WIDTH, cout=bit WIDTH of that result. Then go to IDLE, or directly to RUN if start=1 in DONE (back-to-back adds allowed).
- Latency: from the edge that samples start, done is high in the cycle following the (WIDTH+1)th edge. Throughput is one add per WIDTH+1 cycles.
- start during RUN: ignored, with no effect on operands or result.
- Operand inputs a, b and cin are don't-care except at the accepting edge.
- sum and cout keep their last value through IDLE. They are updated bit-by-bit during RUN, so they are only guaranteed valid when done=1.
- Reset asserted mid-RUN: abort immediately and return to the reset values. No done pulse for the aborted add.
- The counter is $clog2(WIDTH) bits wide. It never wraps in normal operation because the RUN exit is at count WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) and a register holding the carry into bit WIDTH-1.
  - ovf = carry_into_msb XOR cout, i.e. two's-complement signed overflow.
  - ovf is valid with done, held like sum, and reset to 0.
- Undefined: the ovf port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> busy=0, done=0, sum=8'h00, cout=0 immediately, without waiting for an edge.
- a=8'hFF, b=8'h01, cin=0, start pulse -> done after 9 edges, sum=8'h00, cout=1, busy high for 8 cycles.
- a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0. Then start in the DONE cycle with a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, no idle gap.
- Start a=8'h0F, b=8'h01; re-pulse start with a=8'hFF at RUN cycle 3 -> result remains sum=8'h10, cout=0, and exactly one done pulse.
- Start an add, drop rst_n at RUN cycle 4 -> all outputs zero, no done pulse. After release, a=8'h01, b=8'h02 -> sum=8'h03.
- With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1. 8'hFF+8'h01 -> ovf=0, cout=1.
